// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that lets NUM_REQ burst writers share a
// single sync_fifo write port. A lane holds the port until it ends its burst,
// hits MAX_BURST beats, or drops its request. Every release is followed by an
// IDLE cycle so the next winner is picked from a stable lastGrant.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            reqIn,
  input  logic [NUM_REQ-1:0]            validIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] dataIn,
  input  logic [NUM_REQ-1:0]            lastIn,
  output logic [NUM_REQ-1:0]            readyOut,
  output logic [NUM_REQ-1:0]            gntOut,
  input  logic                          full,
  output logic                          wrEnOut,
  output logic [DATA_WIDTH-1:0]         wrDataOut,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state;
  logic [IDX_W-1:0]      last_grant;
  logic [CNT_W-1:0]      beat_cnt;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;

  logic                  lane_req;
  logic                  lane_valid;
  logic                  lane_last;
  logic [DATA_WIDTH-1:0] lane_data;

  logic                  accept;
  logic                  release_now;

  // Round-robin pick: scan from farthest to nearest after lastGrant so the nearest requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (reqIn[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Select the granted lane's signals; lastGrant doubles as the current grant index while in GRANT.
  always_comb begin
    lane_req   = 1'b0;
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    lane_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == last_grant) begin
        lane_req   = reqIn[i];
        lane_valid = validIn[i];
        lane_last  = lastIn[i];
        lane_data  = dataIn[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign readyOut    = gntOut & {NUM_REQ{~full & ~reset}};
  assign accept      = lane_valid & (|(readyOut & gntOut));
  assign wrEnOut     = accept;
  assign wrDataOut   = accept ? lane_data : '0;
  assign busy        = (state == GRANT);
  assign release_now = (accept & lane_last)
                     | (accept & (beat_cnt == CNT_W'(MAX_BURST - 1)))
                     | (~lane_req & ~accept);

  // Grant FSM: take a winner from IDLE, count accepted beats, and release back to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      gntOut     <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= GRANT;
            gntOut     <= NUM_REQ'(1) << pick_idx;
            last_grant <= pick_idx;
            beat_cnt   <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state  <= IDLE;
            gntOut <= '0;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          gntOut <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed bench for fifo_wr_arb with NUM_REQ=4, DATA_WIDTH=8,
// MAX_BURST=16. Inputs change 1 time unit after a rising edge and outputs are
// sampled 1 unit later, well clear of the active edge.
module tb_fifo_wr_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_in;
  logic [3:0]  valid_in;
  logic [3:0]  last_in;
  logic [31:0] data_in;
  logic        full;
  logic [3:0]  ready_out;
  logic [3:0]  gnt_out;
  logic        wr_en_out;
  logic [7:0]  wr_data_out;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  fifo_wr_arb #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .reqIn    (req_in),
    .validIn  (valid_in),
    .dataIn   (data_in),
    .lastIn   (last_in),
    .readyOut (ready_out),
    .gntOut   (gnt_out),
    .full     (full),
    .wrEnOut  (wr_en_out),
    .wrDataOut(wr_data_out),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] valid,
                               input logic [3:0] last, input logic [31:0] data,
                               input logic full_v);
    req_in   = req;
    valid_in = valid;
    last_in  = last;
    data_in  = data;
    full     = full_v;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();
    tick();
    // Reset state
    checkOutput("rst_gnt",   32'(gnt_out),   32'h0);
    checkOutput("rst_busy",  32'(busy),      32'h0);
    checkOutput("rst_wren",  32'(wr_en_out), 32'h0);
    checkOutput("rst_ready", 32'(ready_out), 32'h0);
    reset = 1'b0;

    // Scenario 1: lane 0, three beats A1..A3 with last on the third
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0, 1'b0);
    checkOutput("s1_idle_gnt", 32'(gnt_out), 32'h0);
    tick();
    checkOutput("s1_gnt", 32'(gnt_out), 32'h1);
    checkOutput("s1_busy", 32'(busy), 32'h1);
    for (int b = 0; b < 3; b++) begin
      applyStimulus(4'b0001, 4'b0001, (b == 2) ? 4'b0001 : 4'b0000, 32'(8'hA1 + b), 1'b0);
      checkOutput("s1_ready", 32'(ready_out), 32'h1);
      checkOutput("s1_wren", 32'(wr_en_out), 32'h1);
      checkOutput("s1_data", 32'(wr_data_out), 32'(8'hA1 + b));
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
    checkOutput("s1_rel_gnt", 32'(gnt_out), 32'h0);
    checkOutput("s1_rel_busy", 32'(busy), 32'h0);

    // Scenario 2: reset, then all lanes request with one-beat bursts
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 4'b1111, 32'hB3B2B1B0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      checkOutput("s2_idle_gnt", 32'(gnt_out), 32'h0);
      checkOutput("s2_idle_wren", 32'(wr_en_out), 32'h0);
      tick();
      checkOutput("s2_gnt", 32'(gnt_out), 32'(4'b0001 << (n % 4)));
      checkOutput("s2_data", 32'(wr_data_out), 32'(8'hB0 + (n % 4)));
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();

    // Scenario 3: lane 2 streams 20 beats, lane 0 waits with a one-beat burst
    applyStimulus(4'b0101, 4'b0101, 4'b0001, 32'h000000C0, 1'b0);
    checkOutput("s3_idle_gnt", 32'(gnt_out), 32'h0);
    tick();
    for (int b = 0; b < 16; b++) begin
      applyStimulus(4'b0101, 4'b0101, 4'b0001, {8'h00, 8'(8'h10 + b), 8'h00, 8'hC0}, 1'b0);
      checkOutput("s3_gnt2", 32'(gnt_out), 32'h4);
      checkOutput("s3_data", 32'(wr_data_out), 32'(8'h10 + b));
      tick();
    end
    checkOutput("s3_cap_rel", 32'(gnt_out), 32'h0);
    tick();
    checkOutput("s3_gnt0", 32'(gnt_out), 32'h1);
    checkOutput("s3_data0", 32'(wr_data_out), 32'hC0);
    tick();
    checkOutput("s3_idle2", 32'(gnt_out), 32'h0);
    tick();
    for (int b = 16; b < 20; b++) begin
      applyStimulus(4'b0101, 4'b0101, (b == 19) ? 4'b0101 : 4'b0001,
                    {8'h00, 8'(8'h10 + b), 8'h00, 8'hC0}, 1'b0);
      checkOutput("s3_regnt2", 32'(gnt_out), 32'h4);
      checkOutput("s3_rest", 32'(wr_data_out), 32'(8'h10 + b));
      tick();
    end
    checkOutput("s3_end_gnt", 32'(gnt_out), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();

    // Scenario 4: lane 1 burst of 6 beats, full held for 5 cycles after beat 2
    applyStimulus(4'b0010, 4'b0010, 4'b0000, {16'h0, 8'h30, 8'h0}, 1'b0);
    checkOutput("s4_idle_gnt", 32'(gnt_out), 32'h0);
    tick();
    for (int b = 0; b < 2; b++) begin
      applyStimulus(4'b0010, 4'b0010, 4'b0000, {16'h0, 8'(8'h30 + b), 8'h0}, 1'b0);
      checkOutput("s4_pre_data", 32'(wr_data_out), 32'(8'h30 + b));
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0010, 4'b0010, 4'b0000, {16'h0, 8'h32, 8'h0}, 1'b1);
      checkOutput("s4_full_ready", 32'(ready_out), 32'h0);
      checkOutput("s4_full_wren", 32'(wr_en_out), 32'h0);
      checkOutput("s4_full_data", 32'(wr_data_out), 32'h0);
      checkOutput("s4_full_gnt", 32'(gnt_out), 32'h2);
      tick();
    end
    for (int b = 2; b < 6; b++) begin
      applyStimulus(4'b0010, 4'b0010, (b == 5) ? 4'b0010 : 4'b0000,
                    {16'h0, 8'(8'h30 + b), 8'h0}, 1'b0);
      checkOutput("s4_post_wren", 32'(wr_en_out), 32'h1);
      checkOutput("s4_post_data", 32'(wr_data_out), 32'(8'h30 + b));
      tick();
    end
    checkOutput("s4_end_gnt", 32'(gnt_out), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();

    // Scenario 5: reset pulsed during a lane-3 burst
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 32'h50000000, 1'b0);
    tick();
    checkOutput("s5_gnt3", 32'(gnt_out), 32'h8);
    checkOutput("s5_data0", 32'(wr_data_out), 32'h50);
    tick();
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 32'h51000000, 1'b0);
    checkOutput("s5_data1", 32'(wr_data_out), 32'h51);
    tick();
    reset = 1'b1;
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 32'h52000000, 1'b0);
    checkOutput("s5_rst_wren", 32'(wr_en_out), 32'h0);
    checkOutput("s5_rst_ready", 32'(ready_out), 32'h0);
    tick();
    checkOutput("s5_rst_gnt", 32'(gnt_out), 32'h0);
    checkOutput("s5_rst_busy", 32'(busy), 32'h0);
    checkOutput("s5_rst_wren2", 32'(wr_en_out), 32'h0);
    reset = 1'b0;
    applyStimulus(4'b1001, 4'b1001, 4'b0001, 32'h5F000060, 1'b0);
    checkOutput("s5_idle_gnt", 32'(gnt_out), 32'h0);
    tick();
    checkOutput("s5_gnt0", 32'(gnt_out), 32'h1);
    checkOutput("s5_data_l0", 32'(wr_data_out), 32'h60);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();

    // Scenario 6: lane 1 drops its request mid-burst without last
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 32'h00007000, 1'b0);
    tick();
    checkOutput("s6_gnt1", 32'(gnt_out), 32'h2);
    checkOutput("s6_data0", 32'(wr_data_out), 32'h70);
    tick();
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 32'h00007100, 1'b0);
    checkOutput("s6_data1", 32'(wr_data_out), 32'h71);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
    checkOutput("s6_hold_gnt", 32'(gnt_out), 32'h2);
    checkOutput("s6_hold_wren", 32'(wr_en_out), 32'h0);
    tick();
    checkOutput("s6_rel_gnt", 32'(gnt_out), 32'h0);
    checkOutput("s6_rel_busy", 32'(busy), 32'h0);
    tick();
    checkOutput("s6_stay_idle", 32'(gnt_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing one sync_fifo write port.
REQ-002 Parameter DATA_WIDTH, default 8: write data width, equal to the sync_fifo DATA_WIDTH.
REQ-003 Parameter MAX_BURST, default 16: maximum accepted beats per grant.
REQ-004 The block SHALL have one clock, clock; reset SHALL be synchronous and active-high.
REQ-005 Port clock, input, 1: system clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port reqIn, input, NUM_REQ: bit i high means requester i wants the write port.
REQ-008 Port validIn, input, NUM_REQ: bit i high means requester i presents a beat.
REQ-009 Port dataIn, input, NUM_REQ*DATA_WIDTH: requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port lastIn, input, NUM_REQ: bit i marks the final beat of requester i's burst.
REQ-011 Port readyOut, output, NUM_REQ: bit i high means a beat from requester i is accepted if validIn[i] is high.
REQ-012 Port gntOut, output, NUM_REQ: registered one-hot grant, all-zero when idle.
REQ-013 Port full, input, 1: sync_fifo full flag.
REQ-014 Port wrEnOut, output, 1: sync_fifo wrEnIn.
REQ-015 Port wrDataOut, output, DATA_WIDTH: sync_fifo wrDataIn.
REQ-016 Port busy, output, 1: high while the FSM is in GRANT.

Function
REQ-017 FSM states: IDLE and GRANT only.
REQ-018 In IDLE with any reqIn bit high, the block SHALL pick the first requesting index after lastGrant, wrapping modulo NUM_REQ; on the next edge it SHALL set gntOut to that one-hot value, set lastGrant, clear beatCnt, and enter GRANT.
REQ-019 In IDLE with reqIn all zero, the block SHALL stay in IDLE with gntOut zero.
REQ-020 readyOut[i] = gntOut[i] & ~full & ~reset, combinational; it SHALL be zero for non-granted lanes.
REQ-021 Accept = validIn[g] & readyOut[g] for the granted lane g.
REQ-022 wrEnOut = Accept and wrDataOut = the lane-g slice of dataIn, both combinational with zero latency; wrDataOut SHALL be zero when wrEnOut is low.
REQ-023 beatCnt, width clog2(MAX_BURST+1), SHALL increment by one per Accept and is cleared on grant.
REQ-024 Release from GRANT to IDLE, with gntOut cleared on the same edge, SHALL occur on any of:
- Accept with lastIn[g] high;
- Accept that makes beatCnt reach MAX_BURST;
- reqIn[g] low with no Accept in that cycle.
REQ-025 After a release there SHALL be at least one IDLE cycle before the next grant.
REQ-026 While full is high, the grant SHALL be held, beatCnt held, and wrEnOut kept zero; there is no timeout.
REQ-027 validIn, dataIn and lastIn on non-granted lanes SHALL be ignored.
REQ-028 The block SHALL never assert wrEnOut while full is high, so it never triggers sync_fifo overflow.
REQ-029 Round-robin fairness: with all lanes continuously requesting, each lane SHALL be granted once per NUM_REQ grants.

Reset
REQ-030 On reset the state SHALL be IDLE, gntOut 0, busy 0, beatCnt 0, and lastGrant NUM_REQ-1, so that requester 0 wins first.
REQ-031 While reset is high, wrEnOut and readyOut SHALL be 0.
REQ-032 Reset mid-burst SHALL drop the grant with no further beats written; the partial burst is not resumed.

Verification
REQ-033 Scenario 1: reqIn=0001, 3 beats 0xA1,0xA2,0xA3 with last on the third:
- gntOut=0001 one cycle after reqIn;
- three wrEnOut pulses carrying 0xA1,0xA2,0xA3;
- gntOut=0000 after the last beat.
REQ-034 Scenario 2: reqIn=1111 held, every lane sending 1-beat bursts with last:
- grant order 0,1,2,3,0;
- exactly one IDLE cycle between grants.
REQ-035 Scenario 3: lane 2 streams 20 beats with no last while lane 0 also requests:
- release after 16 beats;
- lane 0 granted next;
- lane 2 regains the grant later and writes the remaining 4 beats.
REQ-036 Scenario 4: full=1 for 5 cycles mid-burst of lane 1:
- readyOut and wrEnOut are 0 and gntOut stays 0010 during those cycles;
- after full drops, all beats are written in order with none lost or duplicated.
REQ-037 Scenario 5: reset pulsed during a lane-3 burst:
- gntOut=0, wrEnOut=0 from the reset cycle on;
- after reset with reqIn=1001, lane 0 is granted first.
REQ-038 Scenario 6: lane 1 deasserts reqIn mid-burst without last → release next edge; gntOut=0000, busy=0.
